// File: rtl/rr_dff_arb_pkg.sv
// Shared types and constants for the round-robin shared-register arbiter.
// Holds the FSM state type, default parameters and the index-width helper.
package rr_dff_arb_pkg;

  localparam int N_REQ_DEFAULT = 4;
  localparam int DW_DEFAULT    = 8;

  typedef enum logic [1:0] {IDLE, GNT, ACK} state_t;

  // Width of a requester index; never below one bit so ports stay legal.
  function automatic int idx_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_dff_arbiter_pick.sv
// Combinational rotate-priority selector: returns the first set request bit
// found when searching upward from start, wrapping modulo N_REQ.
module rr_pick
  import rr_dff_arb_pkg::*;
#(
  parameter  int N_REQ = N_REQ_DEFAULT,
  localparam int IW    = idx_width(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    start,
  output logic [IW-1:0]    sel,
  output logic             found
);

  logic [IW-1:0] idx;

  // NOTE: every variable written here gets a default first so no latch is inferred.
  always_comb begin
    sel   = '0;
    found = 1'b0;
    idx   = '0;
    // Walk offsets from farthest to nearest so the nearest hit is written last.
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = IW'((int'(start) + k) % N_REQ);
      if (req[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_dff_arbiter.sv
// Round-robin arbiter that sequences writes into one shared DW-bit register.
// Optional macro RR_DFF_ARB_LOCK_EN adds a lock input for back-to-back writes.
module rr_dff_arbiter
  import rr_dff_arb_pkg::*;
#(
  parameter  int N_REQ = N_REQ_DEFAULT,
  parameter  int DW    = DW_DEFAULT,
  localparam int IW    = idx_width(N_REQ)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_REQ-1:0]    req,
`ifdef RR_DFF_ARB_LOCK_EN
  input  logic [N_REQ-1:0]    lock,
`endif
  input  logic [N_REQ*DW-1:0] wdata,
  output logic [N_REQ-1:0]    gnt,
  output logic [N_REQ-1:0]    ack,
  output logic [DW-1:0]       q,
  output logic [IW-1:0]       owner,
  output logic                busy
);

  localparam logic [N_REQ-1:0] ONE    = N_REQ'(1);
  localparam logic [IW-1:0]    IDX_LAST = IW'(N_REQ - 1);

  state_t           state_q, state_d;
  logic [N_REQ-1:0] gnt_d, ack_d;
  logic [DW-1:0]    q_d;
  logic [IW-1:0]    owner_d;

  logic [IW-1:0]    start;
  logic [IW-1:0]    pick_sel;
  logic             pick_found;
  logic [DW-1:0]    owner_word;
  logic             hold;

  // Search begins just past the last winner so every requester gets a turn.
  assign start      = (owner == IDX_LAST) ? '0 : owner + IW'(1);
  assign owner_word = wdata[owner*DW +: DW];

`ifdef RR_DFF_ARB_LOCK_EN
  assign hold = lock[owner] & req[owner];
`else
  assign hold = 1'b0;
`endif

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req   (req),
    .start (start),
    .sel   (pick_sel),
    .found (pick_found)
  );

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt;
    ack_d   = '0;
    q_d     = q;
    owner_d = owner;
    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          gnt_d   = ONE << pick_sel;
          owner_d = pick_sel;
          state_d = GNT;
        end
      end
      GNT: begin
        if (req[owner]) begin
          q_d     = owner_word;
          ack_d   = ONE << owner;
          state_d = ACK;
        end else begin
          // Abort: owner is kept so the next search still starts past it.
          gnt_d   = '0;
          state_d = IDLE;
        end
      end
      ACK: begin
        if (hold) begin
          state_d = GNT;
        end else begin
          gnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: begin
        gnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      gnt     <= '0;
      ack     <= '0;
      q       <= '0;
      owner   <= IDX_LAST;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt     <= gnt_d;
      ack     <= ack_d;
      q       <= q_d;
      owner   <= owner_d;
      busy    <= (state_d != IDLE);
    end
  end

endmodule

// File: tb/tb_rr_dff_arbiter.sv
// Self-checking bench for rr_dff_arbiter: directed scenarios then random traffic,
// compared every cycle against a transaction-level round-robin model.
module tb_rr_dff_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int IW = 2;
`ifdef RR_DFF_ARB_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req;
  logic [N-1:0]    lock;
  logic [N*DW-1:0] wdata;
  logic [N-1:0]    gnt, ack;
  logic [DW-1:0]   q;
  logic [IW-1:0]   owner;
  logic            busy;

  int n_pass   = 0;
  int n_checks = 0;
  int n_fail   = 0;

  // Model: who holds the register slot and how far its transaction has got.
  // m_phase 0 = slot free, 1 = granted with write pending, 2 = write just landed.
  int            m_phase, m_owner, m_gnt, m_ack;
  logic [DW-1:0] m_q;

  always #5 clk = ~clk;

  rr_dff_arbiter #(.N_REQ(N), .DW(DW)) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
`ifdef RR_DFF_ARB_LOCK_EN
    .lock  (lock),
`endif
    .wdata (wdata),
    .gnt   (gnt),
    .ack   (ack),
    .q     (q),
    .owner (owner),
    .busy  (busy)
  );

  task automatic model_reset();
    m_phase = 0;
    m_owner = N - 1;
    m_gnt   = -1;
    m_ack   = -1;
    m_q     = '0;
  endtask

  task automatic model_edge();
    if (rst) begin
      model_reset();
      return;
    end
    case (m_phase)
      0: begin
        for (int k = 1; k <= N; k++) begin
          int i;
          i = (m_owner + k) % N;
          if (req[i]) begin
            m_gnt   = i;
            m_owner = i;
            m_phase = 1;
            break;
          end
        end
      end
      1: begin
        if (req[m_owner]) begin
          m_q     = wdata[m_owner*DW +: DW];
          m_ack   = m_owner;
          m_phase = 2;
        end else begin
          m_gnt   = -1;
          m_phase = 0;
        end
      end
      default: begin
        m_ack = -1;
        if (LOCK_EN && lock[m_owner] && req[m_owner]) begin
          m_phase = 1;
        end else begin
          m_gnt   = -1;
          m_phase = 0;
        end
      end
    endcase
  endtask

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic compare_all(string tag);
    check($sformatf("%s.gnt", tag), 32'(gnt), (m_gnt < 0) ? 32'd0 : (32'd1 << m_gnt));
    check($sformatf("%s.ack", tag), 32'(ack), (m_ack < 0) ? 32'd0 : (32'd1 << m_ack));
    check($sformatf("%s.q", tag), 32'(q), 32'(m_q));
    check($sformatf("%s.owner", tag), 32'(owner), 32'(m_owner));
    check($sformatf("%s.busy", tag), 32'(busy), (m_phase != 0) ? 32'd1 : 32'd0);
    check($sformatf("%s.ack_in_gnt", tag), 32'(ack & ~gnt), 32'd0);
  endtask

  // Drive inputs mid-cycle, let one rising edge happen, then compare.
  task automatic step(logic [N-1:0] r, logic [N*DW-1:0] w, logic [N-1:0] l,
                      logic rs, string tag);
    @(negedge clk);
    req   = r;
    wdata = w;
    lock  = l;
    rst   = rs;
    @(posedge clk);
    model_edge();
    #1;
    compare_all(tag);
  endtask

  task automatic reset_cycle();
    step(N'($urandom), $urandom, '0, 1'b1, "reset");
  endtask

  logic [DW-1:0] cont_q [4];
  logic [N-1:0]  r_prev;

  initial begin
    rst   = 1'b1;
    req   = '0;
    lock  = '0;
    wdata = '0;
    model_reset();
    cont_q = '{8'h11, 8'h22, 8'h33, 8'h44};

    // Reset held with random requests.
    reset_cycle();
    reset_cycle();
    check("reset_owner", 32'(owner), 32'd3);

    // Single request from requester 2.
    step(4'b0100, 32'h00A5_0000, '0, 1'b0, "single_gnt");
    check("single_gnt_val", 32'(gnt), 32'h4);
    step(4'b0100, 32'h00A5_0000, '0, 1'b0, "single_ack");
    check("single_ack_val", 32'(ack), 32'h4);
    check("single_q_val", 32'(q), 32'hA5);
    step(4'b0000, 32'h0, '0, 1'b0, "single_done");
    check("single_idle_busy", 32'(busy), 32'd0);

    // Contention from reset: writes land for 0,1,2,3,0.
    reset_cycle();
    for (int i = 0; i < 15; i++) begin
      step(4'b1111, 32'h4433_2211, '0, 1'b0, "contend");
      if (i % 3 == 1) check("contend_q_seq", 32'(q), 32'(cont_q[(i / 3) % 4]));
    end

    // Abort: requester 1 drops during its grant, requester 2 wins next.
    step(4'b0010, 32'h0000_5500, '0, 1'b0, "abort_gnt");
    step(4'b0100, 32'h0077_5500, '0, 1'b0, "abort_drop");
    check("abort_no_ack", 32'(ack), 32'd0);
    step(4'b0100, 32'h0077_5500, '0, 1'b0, "abort_next");
    check("abort_next_gnt", 32'(gnt), 32'h4);
    step(4'b0100, 32'h0077_5500, '0, 1'b0, "abort_write");
    step(4'b0000, 32'h0, '0, 1'b0, "abort_idle");

    // Reset asserted asynchronously while a write is in its ack cycle.
    step(4'b0001, 32'h0000_00C3, '0, 1'b0, "midrst_gnt");
    step(4'b0001, 32'h0000_00C3, '0, 1'b0, "midrst_ack");
    #2 rst = 1'b1;
    #1 model_reset();
    compare_all("midrst_async");
    step(4'b1111, $urandom, '0, 1'b1, "midrst_hold");
    step(4'b1111, 32'h4433_2211, '0, 1'b0, "midrst_first");
    check("midrst_first_gnt", 32'(gnt), 32'h1);
    step(4'b1111, 32'h4433_2211, '0, 1'b0, "midrst_write");
    step(4'b0000, 32'h0, '0, 1'b0, "midrst_idle");

    if (LOCK_EN) begin
      // Lock on requester 3: back-to-back writes until released.
      reset_cycle();
      for (int i = 0; i < 20; i++)
        step(4'b1111, $urandom, 4'b1000, 1'b0, "lock_on");
      for (int i = 0; i < 9; i++)
        step(4'b1111, $urandom, 4'b0000, 1'b0, "lock_off");
    end

    // Random traffic; requests mostly held to mimic the handshake rule.
    r_prev = '0;
    for (int i = 0; i < 400; i++) begin
      logic [N-1:0] r;
      logic [N-1:0] l;
      r = ($urandom_range(0, 3) == 0) ? N'($urandom) : r_prev;
      l = ($urandom_range(0, 4) == 0) ? N'($urandom) : '0;
      r_prev = r;
      step(r, $urandom, l, ($urandom_range(0, 60) == 0), "random");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
